// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard core: the break code, the frame length
// and the active-low seven-segment table.
package ps2_pkg;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam int         FRAME_LEN  = 11;

  // Index is the hex digit; bit0 = segment a ... bit6 = segment g, 0 = lit.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/ps2_keyboard_core_bcd7seg.sv
// Hex digit to active-low seven-segment decoder (module bcd7seg).
module bcd7seg
  import ps2_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[digit];

endmodule

// File: rtl/ps2_keyboard_core.sv
// PS/2 keyboard receiver with scan-code FIFO, key-release counter and hex display.
// Define PS2_PARITY_CHECK_EN to drop frames whose odd parity is wrong.
module ps2_keyboard_core
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       nextdata_n,
  output logic [7:0] scancode,
  output logic       ready,
  output logic       overflow,
  output logic [7:0] count,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic [6:0] hex2,
  output logic [6:0] hex3
);

  localparam int         AW       = $clog2(FIFO_DEPTH);
  localparam logic [3:0] LAST_BIT = 4'(FRAME_LEN - 1);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [2:0]  ps2_sync;
  logic        ps2_fall;
  logic [9:0]  shift_q;
  logic [3:0]  bit_cnt;
  logic        parity_ok;
  logic        frame_ok;
  logic        push_q;
  logic [7:0]  push_byte;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] w_ptr;
  logic [AW:0] r_ptr;
  logic        empty;
  logic        full;
  logic        pop;
  logic        do_write;
  logic [7:0]  scancode_q;
  logic        f0_seen;

  assign ps2_fall = ps2_sync[2] & ~ps2_sync[1];

  // shift_q after ten edges: [0]=start, [8:1]=data, [9]=parity; stop is still on ps2_data.
`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^shift_q[9:1];
`else
  assign parity_ok = shift_q[9] | ~shift_q[9];
`endif

  assign frame_ok = ~shift_q[0] & ps2_data & parity_ok;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ps2_sync  <= 3'b111;
      shift_q   <= '0;
      bit_cnt   <= '0;
      push_q    <= 1'b0;
      push_byte <= '0;
    end else begin
      ps2_sync <= {ps2_sync[1:0], ps2_clk};
      push_q   <= 1'b0;
      if (ps2_fall) begin
        if (bit_cnt == LAST_BIT) begin
          bit_cnt <= '0;
          if (frame_ok) begin
            push_q    <= 1'b1;
            push_byte <= shift_q[8:1];
          end
        end else begin
          shift_q <= {ps2_data, shift_q[9:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end
      end
    end
  end

  assign empty    = (w_ptr == r_ptr);
  assign full     = (w_ptr[AW] != r_ptr[AW]) && (w_ptr[AW-1:0] == r_ptr[AW-1:0]);
  assign pop      = ~nextdata_n & ~empty;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
  assign do_write = push_q & (~full | pop);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      w_ptr      <= '0;
      r_ptr      <= '0;
      overflow   <= 1'b0;
      f0_seen    <= 1'b0;
      count      <= '0;
      scancode_q <= '0;
    end else begin
      scancode_q <= scancode;
      if (do_write) w_ptr <= w_ptr + PTR_ONE;
      if (pop)      r_ptr <= r_ptr + PTR_ONE;
      if (push_q && full && !pop) overflow <= 1'b1;
      if (do_write) begin
        if (push_byte == BREAK_CODE) begin
          f0_seen <= 1'b1;
        end else begin
          if (f0_seen) count <= count + 8'd1;
          f0_seen <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[w_ptr[AW-1:0]] <= push_byte;
  end

  assign ready    = ~empty;
  assign scancode = empty ? scancode_q : mem[r_ptr[AW-1:0]];

  bcd7seg u_hex0 (.digit(scancode[3:0]), .seg(hex0));
  bcd7seg u_hex1 (.digit(scancode[7:4]), .seg(hex1));
  bcd7seg u_hex2 (.digit(count[3:0]),    .seg(hex2));
  bcd7seg u_hex3 (.digit(count[7:4]),    .seg(hex3));

endmodule

// File: tb/tb_ps2_keyboard_core.sv
// Directed self-checking bench for ps2_keyboard_core (FIFO_DEPTH = 8).
module tb_ps2_keyboard_core;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       nextdata_n = 1'b1;
  logic [7:0] scancode;
  logic       ready;
  logic       overflow;
  logic [7:0] count;
  logic [6:0] hex0, hex1, hex2, hex3;

  int checks = 0;
  int errors = 0;
  logic rdy4;
  logic exp_par_ready;

  ps2_keyboard_core #(.FIFO_DEPTH(8)) dut (
    .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .nextdata_n(nextdata_n), .scancode(scancode), .ready(ready),
    .overflow(overflow), .count(count),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One PS/2 bit; ps2_clk falls just after a clk edge, rdy4 is sampled 4 clk later.
  task automatic ps2_bit(input logic b, input logic pop_sync, output logic r4);
    ps2_data = b;
    repeat (4) @(posedge clk);
    #1 ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1 if (pop_sync) nextdata_n = 1'b0;
    @(posedge clk);
    #1 nextdata_n = 1'b1;
    r4 = ready;
    repeat (2) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par,
                            input logic pop_sync, output logic r4);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++)
      ps2_bit(fr[i], pop_sync && (i == 10), r4);
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    check(tag, scancode, exp);
    nextdata_n = 1'b0;
    @(posedge clk);
    #1 nextdata_n = 1'b1;
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    repeat (2) @(posedge clk);
    #1 clrn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", ready, 8'h00);
    check("rst_overflow", overflow, 8'h00);
    check("rst_count", count, 8'h00);
    check("rst_scancode", scancode, 8'h00);
    check("rst_hex0", hex0, 8'h40);
    check("rst_hex3", hex3, 8'h40);
    clrn = 1'b1;
    @(posedge clk);
    #1;

    // Single 1C frame
    send_frame(8'h1C, 1'b0, 1'b0, rdy4);
    check("t1_ready_4clk", rdy4, 8'h01);
    check("t1_scancode", scancode, 8'h1C);
    check("t1_hex0", hex0, 8'h46);
    check("t1_hex1", hex1, 8'h79);
    check("t1_count", count, 8'h00);
    check("t1_hex2", hex2, 8'h40);

    // 1C F0 1C -> one key release
    send_frame(8'hF0, 1'b0, 1'b0, rdy4);
    send_frame(8'h1C, 1'b0, 1'b0, rdy4);
    pop_chk("t2_pop0", 8'h1C);
    pop_chk("t2_pop1", 8'hF0);
    pop_chk("t2_pop2", 8'h1C);
    check("t2_ready", ready, 8'h00);
    check("t2_scancode_hold", scancode, 8'h1C);
    check("t2_count", count, 8'h01);
    check("t2_hex2", hex2, 8'h79);
    check("t2_overflow", overflow, 8'h00);

    // Nine frames into an 8-deep FIFO
    do_reset();
    check("t3_count_after_rst", count, 8'h00);
    for (int i = 0; i < 9; i++) send_frame(8'h10 + 8'(i), 1'b0, 1'b0, rdy4);
    check("t3_overflow", overflow, 8'h01);
    for (int i = 0; i < 8; i++) pop_chk("t3_pop", 8'h10 + 8'(i));
    check("t3_ready_empty", ready, 8'h00);
    check("t3_overflow_sticky", overflow, 8'h01);

    // Wrong parity
    do_reset();
`ifdef PS2_PARITY_CHECK_EN
    exp_par_ready = 1'b0;
`else
    exp_par_ready = 1'b1;
`endif
    send_frame(8'h1C, 1'b1, 1'b0, rdy4);
    check("t4_bad_parity_ready", ready, {7'd0, exp_par_ready});
    if (exp_par_ready) check("t4_bad_parity_data", scancode, 8'h1C);

    // Reset mid-frame
    do_reset();
    send_frame(8'hF0, 1'b0, 1'b0, rdy4);
    send_frame(8'h45, 1'b0, 1'b0, rdy4);
    check("t5_pre_count", count, 8'h01);
    ps2_bit(1'b0, 1'b0, rdy4);
    for (int i = 0; i < 4; i++) ps2_bit(i[0], 1'b0, rdy4);
    clrn = 1'b0;
    @(posedge clk);
    #1;
    check("t5_rst_ready", ready, 8'h00);
    check("t5_rst_overflow", overflow, 8'h00);
    check("t5_rst_count", count, 8'h00);
    check("t5_rst_scancode", scancode, 8'h00);
    check("t5_rst_hex0", hex0, 8'h40);
    check("t5_rst_hex1", hex1, 8'h40);
    check("t5_rst_hex2", hex2, 8'h40);
    check("t5_rst_hex3", hex3, 8'h40);
    @(posedge clk);
    #1 clrn = 1'b1;
    @(posedge clk);
    #1;
    send_frame(8'h32, 1'b0, 1'b0, rdy4);
    check("t5_ready", ready, 8'h01);
    check("t5_hex0", hex0, 8'h24);
    check("t5_hex1", hex1, 8'h30);
    pop_chk("t5_pop", 8'h32);
    check("t5_only_one", ready, 8'h00);
    check("t5_count", count, 8'h00);

    // Push and pop together while full
    do_reset();
    for (int i = 0; i < 8; i++) send_frame(8'h20 + 8'(i), 1'b0, 1'b0, rdy4);
    check("t6_overflow_full", overflow, 8'h00);
    send_frame(8'h55, 1'b0, 1'b1, rdy4);
    check("t6_overflow", overflow, 8'h00);
    for (int i = 1; i < 8; i++) pop_chk("t6_pop", 8'h20 + 8'(i));
    check("t6_ready_last", ready, 8'h01);
    pop_chk("t6_pop_last", 8'h55);
    check("t6_ready_empty", ready, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_core.md
PS2_KEYBOARD_CORE -- requirements
Module: ps2_keyboard_core

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, meaning the number of scan-code FIFO entries (power of two, at least 2).
REQ-002 SHALL have port clk, input, 1 bit: the system clock; all logic rises on its edge.
REQ-003 SHALL have port clrn, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port ps2_clk, input, 1 bit: the raw PS/2 clock from the keyboard.
REQ-005 SHALL have port ps2_data, input, 1 bit: the raw PS/2 data from the keyboard.
REQ-006 SHALL have port nextdata_n, input, 1 bit: active-low pop request.
REQ-007 SHALL have port scancode, output, 8 bits: the FIFO head byte.
REQ-008 SHALL have port ready, output, 1 bit: high when the FIFO is not empty.
REQ-009 SHALL have port overflow, output, 1 bit: sticky flag for a lost frame.
REQ-010 SHALL have port count, output, 8 bits: the key-release counter.
REQ-011 SHALL have ports hex0, hex1, hex2, hex3, outputs, 7 bits each: active-low segments for scancode[3:0], scancode[7:4], count[3:0] and count[7:4].

Function
REQ-012 SHALL synchronize ps2_clk through 3 flops and detect a falling edge as previous synced value 1 and current synced value 0.
REQ-013 SHALL sample ps2_data on each detected edge into a 10-bit shift register with a 4-bit bit counter, giving an 11-bit frame: start, 8 data bits LSB first, odd parity, stop.
REQ-014 SHALL evaluate the frame on the 11th edge and reset the bit counter to 0; the frame is valid when start=0, stop=1 and the parity condition of REQ-028 holds.
REQ-015 SHALL push a valid frame's data byte into the FIFO one clk after the 11th edge is detected; invalid frames are dropped silently.
REQ-016 SHALL assert ready no later than 4 clk cycles after the ps2_clk fall of the stop bit.
REQ-017 SHALL drive scancode as the FIFO head, combinationally; scancode holds its last value when the FIFO is empty.
REQ-018 SHALL pop one entry per clk cycle while nextdata_n=0 and ready=1; a pop while empty is ignored.
REQ-019 SHALL, on push to a full FIFO, drop the byte and set overflow; overflow is cleared only by reset.
REQ-020 SHALL perform both operations when a push and a pop occur in the same cycle; this is legal even when full, and overflow is not set in that case.
REQ-021 SHALL increment count, modulo 256, on each pushed byte that immediately follows a pushed 8'hF0, so that count equals the number of key releases; two consecutive F0 bytes count once.
REQ-022 SHALL decode hex digits combinationally, segment bit0=a to bit6=g, with 0=lit: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
REQ-023 SHALL wrap the FIFO pointers modulo FIFO_DEPTH and use an extra pointer bit to tell full from empty.

Reset
REQ-024 SHALL, while clrn=0, asynchronously clear the FIFO pointers, shift register, bit counter, synchronizer (to 1s), F0-seen flag, count, overflow and the scancode register.
REQ-025 SHALL hold these reset output values: ready=0, overflow=0, count=0, scancode=0, hex0..hex3=7'h40.
REQ-026 SHALL, when reset is asserted mid-frame, discard the partial frame; reception restarts at the next start bit after release.

Configuration
REQ-027 SHALL use macro PS2_PARITY_CHECK_EN to select parity checking.
REQ-028 SHALL, when PS2_PARITY_CHECK_EN is defined, require XOR of the 8 data bits and the parity bit to be 1; when it is undefined, ignore the parity bit.

Structure
REQ-029 SHALL place in shared package ps2_pkg: the break-code constant BREAK_CODE=8'hF0, the frame-length constant 11, and the 16-entry segment table.
REQ-030 SHALL use one sub-module, bcd7seg (4-bit in, 7-bit out), instantiated 4 times; the receiver and FIFO stay inline.

Verification
REQ-031 SHALL cover this case: send 8'h1C with correct parity, then ready=1, scancode=8'h1C, hex0=7'h46, hex1=7'h79, count=0.
REQ-032 SHALL cover this case: send 1C, F0, 1C, then pop 3 times with nextdata_n, then count=1, ready=0 and scancode holds 8'h1C.
REQ-033 SHALL cover this case: send 9 frames with no pop (FIFO_DEPTH=8), then overflow=1 and the 8 oldest bytes pop in order.
REQ-034 SHALL cover this case: send 8'h1C with wrong parity, then with PS2_PARITY_CHECK_EN it is dropped (ready=0), and without it it is accepted.
REQ-035 SHALL cover this case: pulse clrn low after 5 bits of a frame, then a full frame 8'h32, then only 8'h32 is received and all outputs were at reset values during clrn=0.
REQ-036 SHALL cover this case: with the FIFO full, push and pop in the same cycle, then overflow stays 0 and occupancy stays 8.
